// File: rtl/inv_alu.sv
// inv_alu: multi-cycle inverse-operation unit (MUL, SQUARE, POW2).
// Iterative shift-add multiplier behind valid/ready handshakes on both sides.
// Results are loaded into y_o/error_o only on completion and then held.

module inv_alu #(
    parameter int DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    input  logic [3:0]            operation_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [2*DATA_W-1:0]   y_o,
    output logic                  error_o
);

    localparam int RW = 2 * DATA_W;
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_W - 1);

    localparam logic [3:0] OP_MUL    = 4'b0001;
    localparam logic [3:0] OP_SQUARE = 4'b0010;
    localparam logic [3:0] OP_POW2   = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
    } state_t;

    state_t          state;
    logic [RW-1:0]   mcand;
    logic [RW-1:0]   acc;
    logic [DATA_W-1:0] mplier;
    logic [CW-1:0]   count;
    logic            err_pend;

    logic [RW-1:0]   acc_next;
    logic [RW-1:0]   pow2_val;
    logic            pow2_in_range;

    // Accept only from IDLE; decoded straight from the state register.
    assign ready_o = (state == IDLE);

    // Full-width range check on a_i so large exponents are never aliased.
    assign pow2_in_range = (RW'(a_i) < RW'(RW));
    assign pow2_val      = RW'(1) << a_i;

    // One shift-add step: add the multiplicand when the current multiplier LSB is set.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Main FSM. POW2 and illegal ops preload the accumulator and run a single
    // zero-multiplier pass through MULT, which gives them their one-cycle latency
    // and lets every result be published from the same completion point.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            count    <= '0;
            err_pend <= 1'b0;
            valid_o  <= 1'b0;
            y_o      <= '0;
            error_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        state <= MULT;
                        acc   <= '0;
                        count <= '0;
                        case (operation_i)
                            OP_MUL: begin
                                mcand    <= RW'(a_i);
                                mplier   <= b_i;
                                err_pend <= 1'b0;
                            end
                            OP_SQUARE: begin
                                mcand    <= RW'(a_i);
                                mplier   <= a_i;
                                err_pend <= 1'b0;
                            end
                            OP_POW2: begin
                                mcand    <= '0;
                                mplier   <= '0;
                                count    <= LAST_ITER;
                                acc      <= pow2_in_range ? pow2_val : '0;
                                err_pend <= ~pow2_in_range;
                            end
                            default: begin
                                mcand    <= '0;
                                mplier   <= '0;
                                count    <= LAST_ITER;
                                err_pend <= 1'b1;
                            end
                        endcase
                    end
                end
                MULT: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == LAST_ITER) begin
                        y_o     <= acc_next;
                        error_o <= err_pend;
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_alu.sv
// tb_inv_alu: directed-vector bench for inv_alu with hand-computed results.

module tb_inv_alu;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic [3:0]  operation_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] y_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    inv_alu #(.DATA_W(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .operation_i (operation_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .y_o         (y_o),
        .error_o     (error_o)
    );

    // 10 ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: count it and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge and hold it until a rising edge accepts it.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit accepted;
        accepted = 1'b0;
        @(negedge clk_i);
        operation_i = op;
        a_i         = a;
        b_i         = b;
        valid_i     = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (ready_o) begin
                @(posedge clk_i);
                accepted = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        #1;
        valid_i = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    // Count rising edges after the accepting edge until valid_o is seen.
    task automatic waitResult(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) break;
            lat++;
        end
    endtask

    // Full transaction with ready_i already high: latency, result, retirement.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp_y,
                         input logic exp_err, input int exp_lat);
        int lat;
        applyStimulus(op, a, b);
        waitResult(lat);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_y"}, y_o, exp_y);
        checkOutput({tag, "_err"}, error_o, exp_err);
        @(negedge clk_i);
        checkOutput({tag, "_retired_valid"}, valid_o, 0);
        checkOutput({tag, "_retired_ready"}, ready_o, 1);
    endtask

    initial begin
        int lat;
        int stray;

        rst_i       = 1'b1;
        valid_i     = 1'b0;
        ready_i     = 1'b0;
        a_i         = '0;
        b_i         = '0;
        operation_i = '0;

        repeat (2) @(negedge clk_i);
        checkOutput("rst_ready", ready_o, 1);
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_y", y_o, 0);
        checkOutput("rst_err", error_o, 0);
        rst_i = 1'b0;
        ready_i = 1'b1;

        runOp("mul_13x11", 4'b0001, 8'd13, 8'd11, 16'd143, 1'b0, 8);
        runOp("sq_255", 4'b0010, 8'd255, 8'h5A, 16'd65025, 1'b0, 8);
        runOp("sq_0", 4'b0010, 8'd0, 8'h5A, 16'd0, 1'b0, 8);
        runOp("mul_255x255", 4'b0001, 8'd255, 8'd255, 16'd65025, 1'b0, 8);
        runOp("pow2_15", 4'b0100, 8'd15, 8'd0, 16'd32768, 1'b0, 1);
        runOp("pow2_16", 4'b0100, 8'd16, 8'd0, 16'd0, 1'b1, 1);
        runOp("pow2_0", 4'b0100, 8'd0, 8'd0, 16'd1, 1'b0, 1);
        runOp("pow2_144", 4'b0100, 8'd144, 8'd0, 16'd0, 1'b1, 1);
        runOp("ill_0011", 4'b0011, 8'd5, 8'd6, 16'd0, 1'b1, 1);
        runOp("ill_0000", 4'b0000, 8'd5, 8'd6, 16'd0, 1'b1, 1);

        // Noise on the command side while a multiply is in flight.
        applyStimulus(4'b0001, 8'd200, 8'd200);
        @(negedge clk_i);
        operation_i = 4'b0100;
        a_i         = 8'd3;
        b_i         = 8'd77;
        valid_i     = 1'b1;
        checkOutput("busy_ready", ready_o, 0);
        repeat (3) @(negedge clk_i);
        valid_i = 1'b0;
        waitResult(lat);
        checkOutput("noise_latency", lat + 4, 8);
        checkOutput("noise_y", y_o, 40000);
        checkOutput("noise_err", error_o, 0);
        @(negedge clk_i);
        checkOutput("noise_retired", valid_o, 0);

        // Backpressure: result must hold while the sink stalls.
        ready_i = 1'b0;
        applyStimulus(4'b0001, 8'd7, 8'd9);
        waitResult(lat);
        checkOutput("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("bp_hold_y", y_o, 63);
            checkOutput("bp_hold_valid", valid_o, 1);
            checkOutput("bp_hold_ready", ready_o, 0);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("bp_retired_valid", valid_o, 0);
        checkOutput("bp_retired_ready", ready_o, 1);
        checkOutput("bp_keep_y", y_o, 63);

        // Asynchronous reset part way through a multiply.
        applyStimulus(4'b0001, 8'd100, 8'd3);
        repeat (5) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("arst_valid", valid_o, 0);
        checkOutput("arst_y", y_o, 0);
        checkOutput("arst_ready", ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (valid_o) stray++;
        end
        checkOutput("arst_no_result", stray, 0);
        runOp("mul_2x3", 4'b0001, 8'd2, 8'd3, 16'd6, 1'b0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_alu.md
# inv_alu

Multi-cycle companion to the combinational ALU. It computes the inverse operations of that unit: MUL and SQUARE (the inverse of SQRT) with an iterative shift-add multiplier, and POW2 (the inverse of FLOG2). It uses the same one-hot operation encoding and 8-bit operands, and wraps them in a valid/ready handshake on both sides. It sits between the command source and the result sink.

## Interface
Parameters:
- DATA_W, 8, operand width; result width is 2*DATA_W.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- valid_i  input  1  command valid
- ready_o  output  1  block can accept a command (high only in IDLE)
- a_i  input  DATA_W  operand A
- b_i  input  DATA_W  operand B (used by MUL only)
- operation_i  input  4  one-hot op: 4'b0001 MUL, 4'b0010 SQUARE, 4'b0100 POW2, any other value illegal
- valid_o  output  1  result valid
- ready_i  input  1  sink accepts result
- y_o  output  2*DATA_W  result
- error_o  output  1  qualifies y_o; high for illegal op or POW2 out of range

## Operation
- States: IDLE, MULT, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o, latch a_i, b_i and operation_i.
  - MUL: multiplicand=a_i, multiplier=b_i, accumulator=0, iteration count=0 -> MULT.
  - SQUARE: same as MUL, but multiplier=a_i -> MULT.
  - POW2:
    - a_i < 2*DATA_W: y=1<<a_i, error=0.
    - a_i >= 2*DATA_W: y=0, error=1.
    - Goes to DONE.
  - Illegal op: y=0, error=1 -> DONE.
- MULT, one iteration per cycle, multiplier processed LSB-first:
  - If multiplier[0]=1, accumulator += multiplicand (2*DATA_W wide, zero-extended).
  - Multiplicand shifts left by 1; multiplier shifts right by 1; count increments.
  - Always exactly DATA_W iterations. There is no early exit when the multiplier reaches zero.
  - After iteration DATA_W, y=accumulator, error=0 -> DONE.
- DONE:
  - valid_o=1; y_o and error_o are held stable.
  - On valid_o&&ready_i -> IDLE.
- Arithmetic:
  - Unsigned throughout.
  - The product always fits in 2*DATA_W bits, so no overflow is possible.
  - POW2 uses all DATA_W bits of a_i for the range check. a_i is never truncated.
- Inputs are ignored in MULT and DONE. Commands presented while ready_o=0 are not consumed, and the source must hold them.
- Reset (asynchronous, any state, including mid-MULT):
  - State=IDLE, ready_o=1, valid_o=0, y_o=0, error_o=0, all internal registers=0.
  - An in-flight command is discarded with no result.

## Timing
- Reset values: ready_o=1, valid_o=0, y_o=0, error_o=0.
- Accepting edge = T.
  - MUL/SQUARE: valid_o rises after edge T+DATA_W, i.e. 8 cycles for DATA_W=8.
  - POW2/illegal: valid_o rises after edge T+1.
- ready_o is decoded from the state register with no combinational path from valid_i.
- valid_o and y_o are registered with no combinational path from ready_i.
- Result handshake at edge R: valid_o falls and ready_o rises after R. The next command can be accepted at edge R+1.
- Back-to-back MUL throughput is one result per DATA_W+2 cycles when ready_i is held at 1.
- If ready_i is already high when valid_o rises, DONE lasts exactly one cycle.
- y_o and error_o keep the last result after leaving DONE until the next result is loaded. They are only meaningful while valid_o=1.
- valid_i and ready_i asserted in the same cycle are independent: a command can be accepted only in IDLE, and a result can be retired only in DONE.

## Test plan
- MUL a=13, b=11, ready_i=1 -> valid_o high 8 cycles after accept; y_o=143, error_o=0; ready_o back high the cycle after.
- SQUARE a=255 (b=0x5A, ignored) -> y_o=65025 after 8 cycles. SQUARE a=0 -> y_o=0 after 8 cycles.
- POW2:
  - a=15 -> y_o=32768, error_o=0, 1 cycle after accept.
  - a=16 -> y_o=0, error_o=1.
  - a=0 -> y_o=1.
- Illegal op 4'b0011 and 4'b0000 -> y_o=0, error_o=1, 1 cycle after accept. Also, changing operands and asserting valid_i during MULT does not alter an in-progress MUL 200*200=40000.
- Backpressure: MUL 7*9 with ready_i=0 for 5 cycles after valid_o rises -> y_o=63 stable and ready_o=0 throughout; the handshake completes on the first ready_i=1 edge.
- Assert rst_i asynchronously after iteration 4 of MUL 100*3 -> valid_o=0, y_o=0, ready_o=1 immediately. No result emerges. A fresh MUL 2*3 after release gives y_o=6.
